// File: rtl/mod_counter.sv
// Bounded up/down counter over 0..LIMIT with programmable step, wrap or
// saturate at the boundaries, and wrap pulse / sticky overflow flags.
module mod_counter #(
    parameter int WIDTH  = 8,
    parameter int LIMIT  = 2**WIDTH - 1,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [WIDTH-1:0]  ld_val,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrap,
    output logic              ovf
);

    if (LIMIT < 1 || LIMIT > 2**WIDTH - 1 || 2**STEP_W - 1 > LIMIT) begin : g_param_check
        $error("mod_counter: illegal WIDTH/LIMIT/STEP_W combination");
    end

    localparam logic [WIDTH-1:0] LIM_W  = WIDTH'(LIMIT);
    localparam logic [WIDTH:0]   LIM_X  = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   LIM_P1 = (WIDTH+1)'(LIMIT + 1);

    // All boundary arithmetic is one bit wider than count so nothing overflows.
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] up_wrap;
    logic [WIDTH:0] dn_diff;
    logic [WIDTH:0] dn_wrap;
    logic           up_cross;
    logic           dn_cross;

    always_comb begin
        step_x   = {{(WIDTH+1-STEP_W){1'b0}}, step};
        up_sum   = {1'b0, count} + step_x;
        up_wrap  = up_sum - LIM_P1;
        up_cross = up_sum > LIM_X;
        dn_diff  = {1'b0, count} - step_x;
        dn_wrap  = {1'b0, count} + LIM_P1 - step_x;
        dn_cross = {1'b0, count} < step_x;
    end

    assign tc = dir ? (count == LIM_W) : (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (ld) begin
            wrap <= 1'b0;
            if (ld_val > LIM_W) begin
                count <= LIM_W;
                ovf   <= 1'b1;
            end else begin
                count <= ld_val;
            end
        end else if (en && step != '0) begin
            if (dir) begin
                if (up_cross) begin
                    ovf   <= 1'b1;
                    wrap  <= ~sat;
                    count <= sat ? LIM_W : up_wrap[WIDTH-1:0];
                end else begin
                    wrap  <= 1'b0;
                    count <= up_sum[WIDTH-1:0];
                end
            end else begin
                if (dn_cross) begin
                    ovf   <= 1'b1;
                    wrap  <= ~sat;
                    count <= sat ? '0 : dn_wrap[WIDTH-1:0];
                end else begin
                    wrap  <= 1'b0;
                    count <= dn_diff[WIDTH-1:0];
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the count register width in bits.
REQ-002 The block SHALL take parameter LIMIT, default 2**WIDTH-1, as the highest legal count; the legal range is 0..LIMIT.
REQ-003 The block SHALL take parameter STEP_W, default 4, as the step input width; elaboration SHALL fail unless 1 <= LIMIT <= 2**WIDTH-1 and 2**STEP_W-1 <= LIMIT.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous clear.
REQ-007 ld  input  1  synchronous load strobe.
REQ-008 ld_val  input  WIDTH  load value.
REQ-009 en  input  1  count enable.
REQ-010 dir  input  1  direction: 1 = up, 0 = down.
REQ-011 step  input  STEP_W  increment/decrement magnitude per enabled cycle.
REQ-012 sat  input  1  boundary mode: 1 = saturate, 0 = wrap modulo LIMIT+1.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 tc  output  1  combinational terminal count: (dir=1 and count=LIMIT) or (dir=0 and count=0).
REQ-015 wrap  output  1  registered one-cycle pulse: count crossed a boundary in the previous update.
REQ-016 ovf  output  1  registered sticky flag: a boundary crossing or clamp has occurred since the last clear.

Function
REQ-017 Per-edge priority SHALL be: clr, then ld, then en; the lower-priority actions are ignored when a higher one is active.
REQ-018 When clr=1: count<=0, ovf<=0, wrap<=0.
REQ-019 When ld=1 and ld_val<=LIMIT: count<=ld_val, wrap<=0, ovf unchanged.
REQ-020 When ld=1 and ld_val>LIMIT: count<=LIMIT, ovf<=1, wrap<=0.
REQ-021 When en=0 or step=0 (no clr or ld): count holds and wrap<=0.
REQ-022 Up with no crossing (count+step<=LIMIT): count<=count+step, wrap<=0; the sum SHALL be computed at WIDTH+1 bits so it never overflows internally.
REQ-023 Up with crossing, sat=0: count<=count+step-(LIMIT+1), wrap<=1, ovf<=1.
REQ-024 Up with crossing, sat=1: count<=LIMIT, wrap<=0, ovf<=1.
REQ-025 Down with no crossing (step<=count): count<=count-step, wrap<=0.
REQ-026 Down with crossing, sat=0: count<=count+(LIMIT+1)-step, wrap<=1, ovf<=1.
REQ-027 Down with crossing, sat=1: count<=0, wrap<=0, ovf<=1.
REQ-028 Landing exactly on LIMIT (up) or on 0 (down) SHALL NOT count as a crossing.
REQ-029 Holding at a saturated boundary with en=1 SHALL re-assert ovf each cycle, keeping it at 1, and SHALL leave count unchanged.
REQ-030 Changes to dir or sat SHALL take effect on the same edge; no pipeline latency; count update latency is one clock.
REQ-031 tc SHALL follow count and dir combinationally, with no register.
REQ-032 count SHALL never hold a value above LIMIT under any input sequence.

Reset
REQ-033 Asserting rst SHALL immediately force count=0, wrap=0, ovf=0, independent of clk, including mid-count.
REQ-034 While rst=1, all other inputs SHALL be ignored.
REQ-035 The first update after rst deasserts SHALL occur on the first rising clk edge that sees rst=0.

Verification (WIDTH=4, LIMIT=9, STEP_W=2)
REQ-036 The bench SHALL cover: rst pulse between edges while count=7 -> count=0, ovf=0 before next edge.
REQ-037 The bench SHALL cover: sat=0, dir=1, en=1, step=3 from count 8 -> count 1, wrap=1 for one cycle, ovf=1.
REQ-038 The bench SHALL cover: sat=1, dir=0, step=2 from count 1 -> count 0, wrap=0, ovf=1; further cycles hold 0, and tc=1.
REQ-039 The bench SHALL cover: ld=1 with ld_val=12 -> count=9, ovf=1; then clr=1 and ld=1 on the same edge -> count=0, ovf=0.
REQ-040 The bench SHALL cover: sat=0, dir=0, step=3 from count 3 -> count 0, wrap=0, and tc=1 once count=0.
REQ-041 The bench SHALL cover: dir toggled every cycle, step=1, from count 5 -> count alternates 6,5,6,5 with wrap=0.
